// File: rtl/main_memory.sv
// Line-organised main memory behind a single-outstanding request/ack handshake.
// Latency: mem_ack pulses LATENCY cycles after the accepting edge (1..255).
// Backpressure: one request at a time; inputs are ignored until the ack, and a held mem_enable must drop for a cycle first.
//
// Ports:
//    clk, reset              - sole clock, synchronous active-high reset
//    mem_enable, mem_rw      - request valid, 1 = read / 0 = write
//    mem_addr                - byte address; line index taken from the middle bits
//    mem_data_in             - write data (one full line)
//    mem_data_out, mem_ack   - read data (held until next read), one-cycle completion pulse

`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module main_memory #(
   parameter int WIDTH   = `MEMORY_WIDTH,
   parameter int DEPTH   = 4096,
   parameter int LATENCY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_enable,
   input  logic             mem_rw,
   input  logic [31:0]      mem_addr,
   input  logic [WIDTH-1:0] mem_data_in,
   output logic [WIDTH-1:0] mem_data_out,
   output logic             mem_ack
);

   localparam int OFF_W = $clog2(WIDTH / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ACK   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               rw_q, rw_d;
   logic [WIDTH-1:0]   wdat_q, wdat_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               ack_q, ack_d;
   logic               enter_ack;

   logic [WIDTH-1:0]   mem [DEPTH];

   // Offset bits and bits above the line index are deliberately don't-care.
   logic               unused_addr;
   assign unused_addr = ^mem_addr;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rw_d      = rw_q;
      wdat_d    = wdat_q;
      dout_d    = dout_q;
      ack_d     = 1'b0;
      enter_ack = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_enable) begin
               idx_d  = mem_addr[OFF_W+IDX_W-1:OFF_W];
               rw_d   = mem_rw;
               wdat_d = mem_data_in;
               if (LATENCY == 1) begin
                  state_d   = ACK;
                  enter_ack = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         BUSY: begin
            // The counter lands on 0 on the very edge that enters ACK, so the
            // ack appears LATENCY cycles after acceptance, not LATENCY+1.
            if (cnt_q <= 8'd1) begin
               state_d   = ACK;
               cnt_d     = 8'd0;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACK: begin
            state_d = mem_enable ? DRAIN : IDLE;
         end
         DRAIN: begin
            // A request still held from the completed transaction must not be
            // serviced twice; wait for enable to drop.
            if (!mem_enable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (enter_ack) begin
         ack_d = 1'b1;
         if (rw_d) dout_d = mem[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= '0;
         rw_q    <= 1'b0;
         wdat_q  <= '0;
         dout_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rw_q    <= rw_d;
         wdat_q  <= wdat_d;
         dout_q  <= dout_d;
         ack_q   <= ack_d;
      end
   end

   // Array is outside the reset domain; a reset only cancels a pending commit.
   always_ff @(posedge clk) begin
      if (!reset && enter_ack && !rw_d) mem[idx_d] <= wdat_d;
   end

   assign mem_data_out = dout_q;
   assign mem_ack      = ack_q;

endmodule
